// File: rtl/sfx_pkg.sv
// Shared types and constants for the sound-effect arbiter: FSM state encoding,
// effect ids, and default play and gap lengths in frames.
package sfx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } sfx_state_e;

    localparam int SFX_HURT  = 0;
    localparam int SFX_SWORD = 1;
    localparam int SFX_SHEEP = 2;
    localparam int SFX_HEAL  = 3;

    localparam int SFX_FRAMES_DEF = 8;
    localparam int GAP_FRAMES_DEF = 2;

endpackage

// File: rtl/sfx_priority_enc.sv
// Find-first-set over the pending vector: the lowest set index wins, because
// index 0 has the highest priority.
module sfx_priority_enc #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] vec_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    idx_o
);

    always_comb begin
        valid_o = |vec_i;
        idx_o   = '0;
        // Scan from the top down so the lowest set bit is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = ID_W'(i);
        end
    end

endmodule

// File: rtl/sfx_arbiter.sv
// Grants the single tone generator to the highest-priority latched game event,
// plays it for SFX_FRAMES frames, then holds a GAP_FRAMES silent gap.
// Optional macro SFX_PREEMPT_EN: a higher-priority request restarts PLAY with that effect.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IDLE | nothing playing; grants as soon as any request is pending
//  ST_PLAY | effect sfx_id audible; counts frames_left down on frame_end
//  ST_GAP  | silence between effects; counts gap_left down on frame_end
module sfx_arbiter
    import sfx_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int SFX_FRAMES = SFX_FRAMES_DEF,
    parameter int GAP_FRAMES = GAP_FRAMES_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       frame_end,
    input  logic [NUM_REQ-1:0]         req,
    output logic                       sfx_active,
    output logic [$clog2(NUM_REQ)-1:0] sfx_id,
    output logic                       sfx_start,
    output logic [NUM_REQ-1:0]         pending
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int FW   = $clog2(SFX_FRAMES + 1);
    localparam int GW   = (GAP_FRAMES > 0) ? $clog2(GAP_FRAMES + 1) : 1;

    sfx_state_e         state_q;
    logic [NUM_REQ-1:0] pending_q;
    logic [NUM_REQ-1:0] pending_d;
    logic [NUM_REQ-1:0] clr_mask;
    logic               active_q;
    logic               start_q;
    logic [ID_W-1:0]    id_q;
    logic [FW-1:0]      frames_left_q;
    logic [GW-1:0]      gap_left_q;

    logic               win_valid;
    logic [ID_W-1:0]    win_idx;
    logic               preempt;
    logic               grant;

    sfx_priority_enc #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_enc (
        .vec_i   (pending_q),
        .valid_o (win_valid),
        .idx_o   (win_idx)
    );

`ifdef SFX_PREEMPT_EN
    assign preempt = (state_q == ST_PLAY) && win_valid && (win_idx < id_q);
`else
    assign preempt = 1'b0;
`endif

    assign grant = enable && (((state_q == ST_IDLE) && win_valid) || preempt);

    // The winner is cleared after merging new requests, so a same-index
    // request in the grant cycle is absorbed rather than re-arming it.
    always_comb begin
        clr_mask = '0;
        if (grant) clr_mask[win_idx] = 1'b1;
        pending_d = (pending_q | req) & ~clr_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pending_q     <= '0;
            active_q      <= 1'b0;
            start_q       <= 1'b0;
            id_q          <= '0;
            frames_left_q <= '0;
            gap_left_q    <= '0;
        end else if (!enable) begin
            state_q       <= ST_IDLE;
            pending_q     <= '0;
            active_q      <= 1'b0;
            start_q       <= 1'b0;
            frames_left_q <= '0;
            gap_left_q    <= '0;
        end else begin
            start_q   <= 1'b0;
            pending_q <= pending_d;
            case (state_q)
                ST_IDLE: begin
                    if (win_valid) begin
                        id_q          <= win_idx;
                        start_q       <= 1'b1;
                        active_q      <= 1'b1;
                        frames_left_q <= FW'(SFX_FRAMES);
                        state_q       <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    // A regrant cycle ignores frame_end, same as the first grant.
                    if (preempt) begin
                        id_q          <= win_idx;
                        start_q       <= 1'b1;
                        frames_left_q <= FW'(SFX_FRAMES);
                    end else if (frame_end) begin
                        if (frames_left_q == FW'(1)) begin
                            active_q      <= 1'b0;
                            frames_left_q <= '0;
                            if (GAP_FRAMES == 0) begin
                                state_q <= ST_IDLE;
                            end else begin
                                gap_left_q <= GW'(GAP_FRAMES);
                                state_q    <= ST_GAP;
                            end
                        end else begin
                            frames_left_q <= frames_left_q - FW'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (frame_end) begin
                        if (gap_left_q == GW'(1)) begin
                            gap_left_q <= '0;
                            state_q    <= ST_IDLE;
                        end else begin
                            gap_left_q <= gap_left_q - GW'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign sfx_active = active_q;
    assign sfx_id     = id_q;
    assign sfx_start  = start_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_sfx_arbiter.sv
// Scoreboard bench for sfx_arbiter (NUM_REQ=4, SFX_FRAMES=8, GAP_FRAMES=2, frame every 10 cycles).
module tb_sfx_arbiter;

    typedef struct {
        int id;
        int frames;   // expected frame_ends consumed while playing; 0 = cut short, skip
        int gap;      // expected frame_ends between previous end and this start; -1 = skip
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       frame_end;
    logic [3:0] req;
    logic       sfx_active;
    logic [1:0] sfx_id;
    logic       sfx_start;
    logic [3:0] pending;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb_q[$];

    sfx_arbiter #(
        .NUM_REQ    (4),
        .SFX_FRAMES (8),
        .GAP_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .frame_end  (frame_end),
        .req        (req),
        .sfx_active (sfx_active),
        .sfx_id     (sfx_id),
        .sfx_start  (sfx_start),
        .pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running frame pulse, one cycle in every ten.
    initial begin
        frame_end = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            frame_end = (cyc % 10 == 0);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every sfx_start and measures play and gap lengths.
    initial begin
        int   play_cnt = 0;
        int   gap_cnt  = 0;
        int   cur_frames = 0;
        logic prev_active = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (sfx_start) begin
                play_cnt = 0;
                if (sb_q.size() == 0) begin
                    check("unexpected_start_id", int'(sfx_id), -1);
                    cur_frames = 0;
                end else begin
                    e = sb_q.pop_front();
                    check("sb_id", int'(sfx_id), e.id);
                    check("sb_active_with_start", int'(sfx_active), 1);
                    if (e.gap >= 0) check("sb_gap_frames", gap_cnt, e.gap);
                    cur_frames = e.frames;
                end
            end
            if (sfx_active && frame_end) play_cnt++;
            if (prev_active && !sfx_active) begin
                if (cur_frames > 0) check("sb_play_frames", play_cnt, cur_frames);
                cur_frames = 0;
                gap_cnt    = 0;
            end else if (!sfx_active && frame_end) begin
                gap_cnt++;
            end
            prev_active = sfx_active;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input logic [3:0] v);
        req = v;
        step(1);
        req = 4'b0000;
    endtask

    task automatic push(input int id, input int frames, input int gap);
        exp_t e;
        e.id = id; e.frames = frames; e.gap = gap;
        sb_q.push_back(e);
    endtask

    // Waits until everything expected has started and the arbiter has been silent
    // long enough to cover a full gap.
    task automatic wait_done(input string name);
        int quiet = 0;
        int spent = 0;
        while (quiet < 30 && spent < 600) begin
            step(1);
            spent++;
            if (!sfx_active && pending == 4'b0000 && sb_q.size() == 0) quiet++;
            else quiet = 0;
        end
        if (quiet < 30) check({name, "_timeout"}, spent, -1);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        req    = 4'b0000;
        step(2);
        check("rst_active", int'(sfx_active), 0);
        check("rst_id", int'(sfx_id), 0);
        check("rst_start", int'(sfx_start), 0);
        check("rst_pending", int'(pending), 0);
        rst_n = 1'b1;
        step(3);

        // 1: single request, latency and 8-frame play
        push(2, 8, -1);
        pulse(4'b0100);
        check("t1_pending", int'(pending), 4'b0100);
        check("t1_no_early_start", int'(sfx_start), 0);
        step(1);
        check("t1_start", int'(sfx_start), 1);
        check("t1_active", int'(sfx_active), 1);
        check("t1_id", int'(sfx_id), 2);
        check("t1_pending_cleared", int'(pending), 0);
        step(1);
        check("t1_start_one_cycle", int'(sfx_start), 0);
        wait_done("t1");
        check("t1_id_held", int'(sfx_id), 2);

        // 2: two simultaneous requests, priority and gap between them
        push(1, 8, -1);
        push(3, 8, 2);
        pulse(4'b1010);
        step(2);
        check("t2_pending_during_id1", int'(pending), 4'b1000);
        wait_done("t2");

        // 3: higher-priority request while id 3 plays
`ifdef SFX_PREEMPT_EN
        push(3, 0, -1);
        push(0, 8, -1);
`else
        push(3, 8, -1);
        push(0, 8, 2);
`endif
        pulse(4'b1000);
        step(15);
        pulse(4'b0001);
        check("t3_pending0", int'(pending[0]), 1);
        step(1);
`ifdef SFX_PREEMPT_EN
        check("t3_regrant_start", int'(sfx_start), 1);
        check("t3_regrant_id", int'(sfx_id), 0);
        check("t3_pending_cleared", int'(pending), 0);
`else
        check("t3_no_preempt_start", int'(sfx_start), 0);
        check("t3_no_preempt_id", int'(sfx_id), 3);
        check("t3_still_pending", int'(pending), 4'b0001);
`endif
        wait_done("t3");

        // 4: repeated pulses coalesce; same-index request in grant cycle is absorbed
        push(3, 8, -1);
        push(1, 8, 2);
        pulse(4'b1000);
        step(5);
        for (int i = 0; i < 5; i++) begin
            pulse(4'b0010);
            step(2);
        end
        check("t4_coalesced", int'(pending), 4'b0010);
        wait_done("t4");
        push(2, 8, -1);
        req = 4'b0100;
        step(2);
        req = 4'b0000;
        check("t4b_grant_start", int'(sfx_start), 1);
        check("t4b_absorbed", int'(pending), 0);
        wait_done("t4b");

        // 5: enable low mid-play flushes and blocks requests
        push(3, 0, -1);
        pulse(4'b1000);
        step(20);
        pulse(4'b0101);
        check("t5_pending", int'(pending), 4'b0101);
        enable = 1'b0;
        step(1);
        check("t5_inactive", int'(sfx_active), 0);
        check("t5_flushed", int'(pending), 0);
        pulse(4'b0010);
        step(2);
        check("t5_req_ignored", int'(pending), 0);
        check("t5_still_inactive", int'(sfx_active), 0);
        enable = 1'b1;
        step(3);
        check("t5_resume_pending", int'(pending), 0);
        push(2, 8, -1);
        pulse(4'b0100);
        wait_done("t5");

        // 6: grant coincident with frame_end is not counted, then async reset mid-play
        begin
            int guard = 0;
            while (cyc % 10 != 9 && guard < 20) begin
                step(1);
                guard++;
            end
        end
        push(1, 8, -1);
        pulse(4'b0010);
        check("t6_fe_coincident", int'(frame_end), 1);
        wait_done("t6a");
        push(2, 0, -1);
        pulse(4'b0100);
        step(20);
        pulse(4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_active", int'(sfx_active), 0);
        check("t6_rst_id", int'(sfx_id), 0);
        check("t6_rst_start", int'(sfx_start), 0);
        check("t6_rst_pending", int'(pending), 0);
        step(2);
        #3;
        rst_n = 1'b1;
        wait_done("t6b");

        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
